core_debug_ctrl: RTL and testbench

Parametrised debug command controller between the external debugger link and the processor core. It accepts one command at a time: register read, register write, go, interrupt-go, single-step and stop. It drives a generic register-access port and a core run-control handshake, and returns exactly one response per accepted command. Responses carry an error code, and an ack timeout guards against a hung core.

---
 rtl/core_debug_pkg.sv | 56 +++++
 rtl/core_debug_ctrl_if.sv | 49 ++++
 rtl/core_debug_target_check.sv | 24 ++
 rtl/core_debug_ctrl.sv | 169 ++++++++++++++++
 tb/tb_core_debug_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/core_debug_pkg.sv
// core_debug_pkg
//   Shared definitions for the debug command controller: debugger command
//   codes, response error codes, the core run-control encoding, the valid
//   register target windows and the controller state enum.
//   No ports (package).
package core_debug_pkg;

   // Debugger command codes (iCMD_COMMAND)
   localparam logic [3:0] CMD_READ_REG   = 4'h0;
   localparam logic [3:0] CMD_WRITE_REG  = 4'h1;
   localparam logic [3:0] CMD_GO         = 4'h8;
   localparam logic [3:0] CMD_INTGO      = 4'h9;
   localparam logic [3:0] CMD_SINGLESTEP = 4'hA;
   localparam logic [3:0] CMD_STOP       = 4'hF;

   // Response error codes (oRESP_ERRCODE)
   localparam logic [2:0] ERR_OK          = 3'd0;
   localparam logic [2:0] ERR_ILLEGAL_CMD = 3'd1;
   localparam logic [2:0] ERR_NOT_STOPPED = 3'd2;
   localparam logic [2:0] ERR_BAD_TARGET  = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT     = 3'd4;

   // Core run-control encoding (oDEBUG_CORE_CMD)
   localparam logic [1:0] CORE_STOP  = 2'd0;
   localparam logic [1:0] CORE_GO    = 2'd1;
   localparam logic [1:0] CORE_INTGO = 2'd2;
   localparam logic [1:0] CORE_STEP  = 2'd3;

   // Register target windows: general registers start at GR_BASE,
   // system registers 64..78, previous-context registers 128..132.
   localparam int unsigned GR_BASE   = 0;
   localparam int unsigned SYS_FIRST = 64;
   localparam int unsigned SYS_LAST  = 78;
   localparam int unsigned PCX_FIRST = 128;
   localparam int unsigned PCX_LAST  = 132;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REG_WAIT,
      ST_CORE_WAIT,
      ST_RESP
   } state_t;

   // Translate a run-control debugger command into the core encoding.
   function automatic logic [1:0] core_cmd_map(input logic [3:0] cmd);
      logic [1:0] enc;
      case (cmd)
         CMD_GO:         enc = CORE_GO;
         CMD_INTGO:      enc = CORE_INTGO;
         CMD_SINGLESTEP: enc = CORE_STEP;
         default:        enc = CORE_STOP;
      endcase
      return enc;
   endfunction

endpackage

// File: rtl/core_debug_ctrl_if.sv
// core_debug_ctrl_if
//   Bundles the debugger command/response link, the core run-control
//   handshake and the register-access port of core_debug_ctrl.
//   Modports:
//     slave  - the controller (receives commands, drives core/register ports)
//     master - the environment (debugger, core and register file side)
interface core_debug_ctrl_if #(
   parameter int DATA_W   = 32,
   parameter int TARGET_W = 8
);
   // Debugger command / response
   logic                iCMD_REQ;
   logic                oCMD_BUSY;
   logic [3:0]          iCMD_COMMAND;
   logic [TARGET_W-1:0] iCMD_TARGET;
   logic [DATA_W-1:0]   iCMD_DATA;
   logic                oRESP_VALID;
   logic                oRESP_ERROR;
   logic [2:0]          oRESP_ERRCODE;
   logic [DATA_W-1:0]   oRESP_DATA;
   // Core run control
   logic                oDEBUG_CORE_REQ;
   logic [1:0]          oDEBUG_CORE_CMD;
   logic                iDEBUG_CORE_ACK;
   logic                oCORE_STOPPED;
   // Register access
   logic                oREG_REQ;
   logic                oREG_WE;
   logic [TARGET_W-1:0] oREG_ADDR;
   logic [DATA_W-1:0]   oREG_WDATA;
   logic                iREG_VALID;
   logic [DATA_W-1:0]   iREG_RDATA;

   modport slave (
      input  iCMD_REQ, iCMD_COMMAND, iCMD_TARGET, iCMD_DATA,
             iDEBUG_CORE_ACK, iREG_VALID, iREG_RDATA,
      output oCMD_BUSY, oRESP_VALID, oRESP_ERROR, oRESP_ERRCODE, oRESP_DATA,
             oDEBUG_CORE_REQ, oDEBUG_CORE_CMD, oCORE_STOPPED,
             oREG_REQ, oREG_WE, oREG_ADDR, oREG_WDATA
   );

   modport master (
      output iCMD_REQ, iCMD_COMMAND, iCMD_TARGET, iCMD_DATA,
             iDEBUG_CORE_ACK, iREG_VALID, iREG_RDATA,
      input  oCMD_BUSY, oRESP_VALID, oRESP_ERROR, oRESP_ERRCODE, oRESP_DATA,
             oDEBUG_CORE_REQ, oDEBUG_CORE_CMD, oCORE_STOPPED,
             oREG_REQ, oREG_WE, oREG_ADDR, oREG_WDATA
   );
endinterface

// File: rtl/core_debug_target_check.sv
// core_debug_target_check
//   Combinational register-target validator.
//   Ports:
//     target   in  TARGET_W  register target index
//     valid    out 1         target lies in the GR, system or
//                            previous-context window
module core_debug_target_check
   import core_debug_pkg::*;
#(
   parameter int TARGET_W = 8,
   parameter int NUM_GR   = 32
) (
   input  logic [TARGET_W-1:0] target,
   output logic                valid
);
   logic [31:0] t;

   always_comb begin
      t     = 32'(target);
      valid = (t < GR_BASE + 32'(NUM_GR))
           || (t >= SYS_FIRST && t <= SYS_LAST)
           || (t >= PCX_FIRST && t <= PCX_LAST);
   end
endmodule

// File: rtl/core_debug_ctrl.sv
// core_debug_ctrl
//   Debug command controller between the debugger link and the core.
//   Accepts one command at a time, performs a register access or a core
//   run-control handshake, and returns exactly one response per command.
//   Ports:
//     iCLOCK       in  sole clock, rising edge
//     iRESET_SYNC  in  synchronous active-high reset
//     bus          core_debug_ctrl_if.slave: command/response, core
//                  run-control and register-access signals
module core_debug_ctrl
   import core_debug_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int TARGET_W = 8,
   parameter int NUM_GR   = 32,
   parameter int TIMEOUT  = 256
) (
   input  logic             iCLOCK,
   input  logic             iRESET_SYNC,
   core_debug_ctrl_if.slave bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state, state_nxt;
   logic [3:0]          cmd_q;
   logic [TARGET_W-1:0] target_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [2:0]          errcode_q;
   logic [DATA_W-1:0]   resp_data_q;
   logic                core_stopped_q;
   logic [CNT_W-1:0]    tmo_cnt;

   logic       tgt_ok;
   logic [2:0] accept_err;
   logic       accept;
   logic       resp_load;
   logic       rdata_load;
   logic [2:0] errcode_nxt;
   logic       stopped_nxt;
   logic       tmo_last;

   core_debug_target_check #(
      .TARGET_W (TARGET_W),
      .NUM_GR   (NUM_GR)
   ) u_target_check (
      .target (bus.iCMD_TARGET),
      .valid  (tgt_ok)
   );

   // Error classification of the command presented in IDLE. The case order
   // gives the priority: illegal code, then core not halted, then target.
   always_comb begin
      accept_err = ERR_OK;
      case (bus.iCMD_COMMAND)
         CMD_READ_REG, CMD_WRITE_REG: begin
            if (!core_stopped_q)  accept_err = ERR_NOT_STOPPED;
            else if (!tgt_ok)     accept_err = ERR_BAD_TARGET;
         end
         CMD_SINGLESTEP: begin
            if (!core_stopped_q)  accept_err = ERR_NOT_STOPPED;
         end
         CMD_GO, CMD_INTGO, CMD_STOP: accept_err = ERR_OK;
         default:                     accept_err = ERR_ILLEGAL_CMD;
      endcase
   end

   assign tmo_last = (tmo_cnt == TMO_LAST);

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   // A valid/ack on the final wait cycle is checked before the timeout,
   // so it wins and the command completes normally.
   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      resp_load   = 1'b0;
      rdata_load  = 1'b0;
      errcode_nxt = ERR_OK;
      stopped_nxt = core_stopped_q;
      case (state)
         ST_IDLE: begin
            if (bus.iCMD_REQ) begin
               accept      = 1'b1;
               errcode_nxt = accept_err;
               if (accept_err != ERR_OK) begin
                  state_nxt = ST_RESP;
                  resp_load = 1'b1;
               end else if (bus.iCMD_COMMAND == CMD_READ_REG ||
                            bus.iCMD_COMMAND == CMD_WRITE_REG) begin
                  state_nxt = ST_REG_WAIT;
               end else begin
                  state_nxt = ST_CORE_WAIT;
               end
            end
         end
         ST_REG_WAIT: begin
            if (bus.iREG_VALID) begin
               state_nxt  = ST_RESP;
               resp_load  = 1'b1;
               rdata_load = (cmd_q == CMD_READ_REG);
            end else if (tmo_last) begin
               state_nxt   = ST_RESP;
               resp_load   = 1'b1;
               errcode_nxt = ERR_TIMEOUT;
            end
         end
         ST_CORE_WAIT: begin
            if (bus.iDEBUG_CORE_ACK) begin
               state_nxt = ST_RESP;
               resp_load = 1'b1;
               if (cmd_q == CMD_STOP)                            stopped_nxt = 1'b1;
               else if (cmd_q == CMD_GO || cmd_q == CMD_INTGO)   stopped_nxt = 1'b0;
            end else if (tmo_last) begin
               state_nxt   = ST_RESP;
               resp_load   = 1'b1;
               errcode_nxt = ERR_TIMEOUT;
            end
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         core_stopped_q <= 1'b0;
         errcode_q      <= ERR_OK;
         resp_data_q    <= '0;
         tmo_cnt        <= '0;
      end else begin
         core_stopped_q <= stopped_nxt;
         if (resp_load) begin
            errcode_q   <= errcode_nxt;
            resp_data_q <= rdata_load ? bus.iREG_RDATA : '0;
         end
         if (accept)
            tmo_cnt <= '0;
         else if (state == ST_REG_WAIT || state == ST_CORE_WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Command capture; the request outputs are gated by state, so these
   // need no reset to present zeros after reset.
   always_ff @(posedge iCLOCK) begin
      if (accept) begin
         cmd_q    <= bus.iCMD_COMMAND;
         target_q <= bus.iCMD_TARGET;
         wdata_q  <= bus.iCMD_DATA;
      end
   end

   assign bus.oCMD_BUSY       = (state != ST_IDLE);
   assign bus.oRESP_VALID     = (state == ST_RESP);
   assign bus.oRESP_ERRCODE   = errcode_q;
   assign bus.oRESP_ERROR     = (errcode_q != ERR_OK);
   assign bus.oRESP_DATA      = resp_data_q;
   assign bus.oCORE_STOPPED   = core_stopped_q;
   assign bus.oREG_REQ        = (state == ST_REG_WAIT);
   assign bus.oREG_WE         = (state == ST_REG_WAIT) && (cmd_q == CMD_WRITE_REG);
   assign bus.oREG_ADDR       = (state == ST_REG_WAIT) ? target_q : '0;
   assign bus.oREG_WDATA      = (state == ST_REG_WAIT) ? wdata_q  : '0;
   assign bus.oDEBUG_CORE_REQ = (state == ST_CORE_WAIT);
   assign bus.oDEBUG_CORE_CMD = (state == ST_CORE_WAIT) ? core_cmd_map(cmd_q) : CORE_STOP;
endmodule

// File: tb/tb_core_debug_ctrl.sv
// tb_core_debug_ctrl
//   Directed bench for core_debug_ctrl with TIMEOUT=8. Inputs are driven and
//   outputs sampled 1 ns after each rising edge.
module tb_core_debug_ctrl;
   logic iCLOCK = 1'b0;
   logic iRESET_SYNC;
   int   vectors = 0;
   int   miscompares = 0;

   core_debug_ctrl_if #(.DATA_W(32), .TARGET_W(8)) bus ();

   core_debug_ctrl #(
      .DATA_W(32), .TARGET_W(8), .NUM_GR(32), .TIMEOUT(8)
   ) dut (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .bus         (bus)
   );

   always #5 iCLOCK = ~iCLOCK;

   task automatic tick();
      @(posedge iCLOCK);
      #1;
   endtask

   // Present a command for one cycle (accept cycle T); returns in cycle T+1.
   task automatic issue(input logic [3:0] cmd, input logic [7:0] tgt, input logic [31:0] data);
      bus.iCMD_REQ     = 1'b1;
      bus.iCMD_COMMAND = cmd;
      bus.iCMD_TARGET  = tgt;
      bus.iCMD_DATA    = data;
      tick();
      bus.iCMD_REQ     = 1'b0;
   endtask

   task automatic test_reset();
      iRESET_SYNC = 1'b1;
      bus.iCMD_REQ = 0; bus.iCMD_COMMAND = 0; bus.iCMD_TARGET = 0; bus.iCMD_DATA = 0;
      bus.iDEBUG_CORE_ACK = 0; bus.iREG_VALID = 0; bus.iREG_RDATA = 0;
      tick(); tick();
      iRESET_SYNC = 1'b0;
      tick();
      vectors++; if (bus.oCMD_BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.oCMD_BUSY); end
      vectors++; if ({bus.oRESP_VALID, bus.oRESP_ERROR, bus.oRESP_ERRCODE} !== 5'b0) begin miscompares++; $display("FAIL reset_resp: got %b%b%h want 0", bus.oRESP_VALID, bus.oRESP_ERROR, bus.oRESP_ERRCODE); end
      vectors++; if (bus.oRESP_DATA !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.oRESP_DATA); end
      vectors++; if ({bus.oDEBUG_CORE_REQ, bus.oDEBUG_CORE_CMD, bus.oCORE_STOPPED} !== 4'b0) begin miscompares++; $display("FAIL reset_core: got %b want 0", {bus.oDEBUG_CORE_REQ, bus.oDEBUG_CORE_CMD, bus.oCORE_STOPPED}); end
      vectors++; if ({bus.oREG_REQ, bus.oREG_WE, bus.oREG_ADDR, bus.oREG_WDATA} !== 42'b0) begin miscompares++; $display("FAIL reset_reg: got %h want 0", {bus.oREG_REQ, bus.oREG_WE, bus.oREG_ADDR, bus.oREG_WDATA}); end
   endtask

   task automatic test_errors_running();
      issue(4'h0, 8'd5, 32'h0);
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd2) begin miscompares++; $display("FAIL read_running: valid %b code %0d want 1/2", bus.oRESP_VALID, bus.oRESP_ERRCODE); end
      vectors++; if (bus.oRESP_ERROR !== 1'b1) begin miscompares++; $display("FAIL read_running_err: got %b want 1", bus.oRESP_ERROR); end
      vectors++; if (bus.oREG_REQ !== 1'b0) begin miscompares++; $display("FAIL read_running_noreq: got %b want 0", bus.oREG_REQ); end
      tick();
      issue(4'h3, 8'd5, 32'h0);
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd1) begin miscompares++; $display("FAIL illegal_cmd: valid %b code %0d want 1/1", bus.oRESP_VALID, bus.oRESP_ERRCODE); end
      tick();
      vectors++; if (bus.oCMD_BUSY !== 1'b0 || bus.oRESP_VALID !== 1'b0) begin miscompares++; $display("FAIL err_return_idle: busy %b valid %b want 0/0", bus.oCMD_BUSY, bus.oRESP_VALID); end
   endtask

   task automatic test_stop_read();
      issue(4'hF, 8'd0, 32'h0);                        // now T+1
      vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b1 || bus.oDEBUG_CORE_CMD !== 2'd0) begin miscompares++; $display("FAIL stop_req: req %b cmd %0d want 1/0", bus.oDEBUG_CORE_REQ, bus.oDEBUG_CORE_CMD); end
      vectors++; if (bus.oCMD_BUSY !== 1'b1) begin miscompares++; $display("FAIL stop_busy: got %b want 1", bus.oCMD_BUSY); end
      tick();                                          // T+2
      vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b1 || bus.oRESP_VALID !== 1'b0) begin miscompares++; $display("FAIL stop_hold: req %b valid %b want 1/0", bus.oDEBUG_CORE_REQ, bus.oRESP_VALID); end
      tick();                                          // T+3: ack
      bus.iDEBUG_CORE_ACK = 1'b1;
      tick();                                          // T+4: response
      bus.iDEBUG_CORE_ACK = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd0 || bus.oRESP_ERROR !== 1'b0) begin miscompares++; $display("FAIL stop_resp: valid %b code %0d want 1/0", bus.oRESP_VALID, bus.oRESP_ERRCODE); end
      vectors++; if (bus.oCORE_STOPPED !== 1'b1 || bus.oDEBUG_CORE_REQ !== 1'b0) begin miscompares++; $display("FAIL stop_state: stopped %b req %b want 1/0", bus.oCORE_STOPPED, bus.oDEBUG_CORE_REQ); end
      tick();
      issue(4'h0, 8'd5, 32'h0);
      vectors++; if (bus.oREG_REQ !== 1'b1 || bus.oREG_WE !== 1'b0 || bus.oREG_ADDR !== 8'd5) begin miscompares++; $display("FAIL read_req: req %b we %b addr %0d want 1/0/5", bus.oREG_REQ, bus.oREG_WE, bus.oREG_ADDR); end
      bus.iREG_VALID = 1'b1; bus.iREG_RDATA = 32'hDEADBEEF;
      tick();
      bus.iREG_VALID = 1'b0; bus.iREG_RDATA = 32'h0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_DATA !== 32'hDEADBEEF || bus.oRESP_ERRCODE !== 3'd0) begin miscompares++; $display("FAIL read_resp: valid %b data %h code %0d want 1/deadbeef/0", bus.oRESP_VALID, bus.oRESP_DATA, bus.oRESP_ERRCODE); end
      vectors++; if (bus.oREG_REQ !== 1'b0) begin miscompares++; $display("FAIL read_req_drop: got %b want 0", bus.oREG_REQ); end
      tick();
   endtask

   task automatic test_write();
      issue(4'h1, 8'd67, 32'h1000);
      vectors++; if (bus.oREG_REQ !== 1'b1 || bus.oREG_WE !== 1'b1 || bus.oREG_ADDR !== 8'd67 || bus.oREG_WDATA !== 32'h1000) begin miscompares++; $display("FAIL write_req: req %b we %b addr %0d wdata %h want 1/1/67/1000", bus.oREG_REQ, bus.oREG_WE, bus.oREG_ADDR, bus.oREG_WDATA); end
      tick();
      vectors++; if (bus.oREG_REQ !== 1'b1 || bus.oREG_WDATA !== 32'h1000) begin miscompares++; $display("FAIL write_hold: req %b wdata %h want 1/1000", bus.oREG_REQ, bus.oREG_WDATA); end
      bus.iREG_VALID = 1'b1; bus.iREG_RDATA = 32'h5555AAAA;
      tick();
      bus.iREG_VALID = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd0 || bus.oRESP_DATA !== 32'h0) begin miscompares++; $display("FAIL write_resp: valid %b code %0d data %h want 1/0/0", bus.oRESP_VALID, bus.oRESP_ERRCODE, bus.oRESP_DATA); end
      tick();
   endtask

   task automatic test_bad_target();
      issue(4'h0, 8'd40, 32'h0);
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd3 || bus.oREG_REQ !== 1'b0) begin miscompares++; $display("FAIL bad_target_40: valid %b code %0d req %b want 1/3/0", bus.oRESP_VALID, bus.oRESP_ERRCODE, bus.oREG_REQ); end
      tick();
      issue(4'h1, 8'd133, 32'h0);
      vectors++; if (bus.oRESP_ERRCODE !== 3'd3) begin miscompares++; $display("FAIL bad_target_133: got %0d want 3", bus.oRESP_ERRCODE); end
      tick();
      issue(4'h0, 8'd132, 32'h0);
      vectors++; if (bus.oREG_REQ !== 1'b1 || bus.oRESP_VALID !== 1'b0) begin miscompares++; $display("FAIL target_132_ok: req %b valid %b want 1/0", bus.oREG_REQ, bus.oRESP_VALID); end
      bus.iREG_VALID = 1'b1; bus.iREG_RDATA = 32'h13213213;
      tick();
      bus.iREG_VALID = 1'b0;
      tick();
   endtask

   task automatic test_step_intgo();
      issue(4'hA, 8'd0, 32'h0);
      vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b1 || bus.oDEBUG_CORE_CMD !== 2'd3) begin miscompares++; $display("FAIL step_cmd: req %b cmd %0d want 1/3", bus.oDEBUG_CORE_REQ, bus.oDEBUG_CORE_CMD); end
      bus.iDEBUG_CORE_ACK = 1'b1;
      tick();
      bus.iDEBUG_CORE_ACK = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd0 || bus.oCORE_STOPPED !== 1'b1) begin miscompares++; $display("FAIL step_resp: valid %b code %0d stopped %b want 1/0/1", bus.oRESP_VALID, bus.oRESP_ERRCODE, bus.oCORE_STOPPED); end
      tick();
      issue(4'h9, 8'd0, 32'h0);
      vectors++; if (bus.oDEBUG_CORE_CMD !== 2'd2) begin miscompares++; $display("FAIL intgo_cmd: got %0d want 2", bus.oDEBUG_CORE_CMD); end
      bus.iDEBUG_CORE_ACK = 1'b1;
      tick();
      bus.iDEBUG_CORE_ACK = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oCORE_STOPPED !== 1'b0) begin miscompares++; $display("FAIL intgo_resp: valid %b stopped %b want 1/0", bus.oRESP_VALID, bus.oCORE_STOPPED); end
      tick();
   endtask

   task automatic test_timeout();
      issue(4'h8, 8'd0, 32'h0);                        // GO, never acked
      for (int i = 0; i < 8; i++) begin
         vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b1 || bus.oDEBUG_CORE_CMD !== 2'd1) begin miscompares++; $display("FAIL tmo_req_cycle%0d: req %b cmd %0d want 1/1", i, bus.oDEBUG_CORE_REQ, bus.oDEBUG_CORE_CMD); end
         tick();
      end
      vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b0 || bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd4) begin miscompares++; $display("FAIL tmo_resp: req %b valid %b code %0d want 0/1/4", bus.oDEBUG_CORE_REQ, bus.oRESP_VALID, bus.oRESP_ERRCODE); end
      bus.iDEBUG_CORE_ACK = 1'b1;                      // late ack in RESP and IDLE
      tick(); tick();
      bus.iDEBUG_CORE_ACK = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b0 || bus.oCMD_BUSY !== 1'b0 || bus.oCORE_STOPPED !== 1'b0) begin miscompares++; $display("FAIL tmo_late_ack: valid %b busy %b stopped %b want 0/0/0", bus.oRESP_VALID, bus.oCMD_BUSY, bus.oCORE_STOPPED); end
      issue(4'hF, 8'd0, 32'h0);                        // STOP acked on final wait cycle
      for (int i = 0; i < 7; i++) tick();
      vectors++; if (bus.oDEBUG_CORE_REQ !== 1'b1) begin miscompares++; $display("FAIL tmo_last_req: got %b want 1", bus.oDEBUG_CORE_REQ); end
      bus.iDEBUG_CORE_ACK = 1'b1;
      tick();
      bus.iDEBUG_CORE_ACK = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b1 || bus.oRESP_ERRCODE !== 3'd0 || bus.oCORE_STOPPED !== 1'b1) begin miscompares++; $display("FAIL tmo_last_ack: valid %b code %0d stopped %b want 1/0/1", bus.oRESP_VALID, bus.oRESP_ERRCODE, bus.oCORE_STOPPED); end
      tick();
   endtask

   task automatic test_back_to_back();
      int resp_seen = 0;
      bus.iCMD_REQ = 1'b1; bus.iCMD_COMMAND = 4'h0; bus.iCMD_TARGET = 8'd1; bus.iCMD_DATA = 32'h0;
      bus.iREG_VALID = 1'b1; bus.iREG_RDATA = 32'hCAFEF00D;
      for (int i = 0; i < 9; i++) begin
         vectors++; if (bus.oCMD_BUSY !== (i % 3 != 0)) begin miscompares++; $display("FAIL b2b_busy_%0d: got %b want %b", i, bus.oCMD_BUSY, (i % 3 != 0)); end
         vectors++; if (bus.oRESP_VALID !== (i % 3 == 2)) begin miscompares++; $display("FAIL b2b_valid_%0d: got %b want %b", i, bus.oRESP_VALID, (i % 3 == 2)); end
         if (bus.oRESP_VALID === 1'b1) resp_seen++;
         tick();
      end
      bus.iCMD_REQ = 1'b0;
      bus.iREG_VALID = 1'b0;
      vectors++; if (resp_seen != 3) begin miscompares++; $display("FAIL b2b_count: got %0d want 3", resp_seen); end
      vectors++; if (bus.oRESP_DATA !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_data: got %h want cafef00d", bus.oRESP_DATA); end
      tick();
      vectors++; if (bus.oCMD_BUSY !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", bus.oCMD_BUSY); end
   endtask

   task automatic test_reset_mid();
      issue(4'h0, 8'd2, 32'h0);
      vectors++; if (bus.oREG_REQ !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req: got %b want 1", bus.oREG_REQ); end
      iRESET_SYNC = 1'b1;
      tick();
      iRESET_SYNC = 1'b0;
      vectors++; if (bus.oREG_REQ !== 1'b0 || bus.oREG_ADDR !== 8'd0 || bus.oCMD_BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_mid_reg: req %b addr %0d busy %b want 0/0/0", bus.oREG_REQ, bus.oREG_ADDR, bus.oCMD_BUSY); end
      vectors++; if (bus.oRESP_VALID !== 1'b0 || bus.oRESP_DATA !== 32'h0 || bus.oCORE_STOPPED !== 1'b0) begin miscompares++; $display("FAIL rst_mid_out: valid %b data %h stopped %b want 0/0/0", bus.oRESP_VALID, bus.oRESP_DATA, bus.oCORE_STOPPED); end
      bus.iREG_VALID = 1'b1;                           // late valid after abort
      tick();
      bus.iREG_VALID = 1'b0;
      vectors++; if (bus.oRESP_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_mid_noresp: got %b want 0", bus.oRESP_VALID); end
   endtask

   initial begin
      test_reset();
      test_errors_running();
      test_stop_read();
      test_write();
      test_bad_target();
      test_step_intgo();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
